axis_spi_master: RTL and testbench
==================================

Name: axis_spi_master

Overview:
- AXI-Stream to SPI master: one s_axis word becomes one chip-select-framed SPI transaction, and the word received on MISO is returned on m_axis.
- This is the upstream link partner for axis_spi_slave. It drives spi_clk/spi_cs/spi_mosi and samples spi_miso.
- It shares the SPI_MODE encoding with the slave: mode 0/1/2/3 = CPOL,CPHA 00/01/10/11.
- Fully synchronous to clk_i. SCLK is generated by a counter, not by a clock net.

Parameters:
- SPI_MODE, 1: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]. Values 0..3.
- DATA_WIDTH, 8: bits per word, MSB first. Must be >= 2.
- CLK_DIV, 4: SCLK half-period in clk_i cycles. Must be >= 1. f_sclk = f_clk/(2*CLK_DIV).

Ports:
- clk_i  input  1  system clock
- arstn_i  input  1  asynchronous active-low reset
- spi_clk_o  output  1  SPI clock; idles at CPOL
- spi_cs_o  output  1  chip select, active low
- spi_mosi_o  output  1  master out
- spi_miso_i  input  1  master in; the bench/system guarantees it is stable around sample edges
- s_axis  axis_if.slave  DATA_WIDTH  TX word (tdata, tvalid, tready)
- m_axis  axis_if.master  DATA_WIDTH  RX word (tdata, tvalid, tready)

Behaviour:
- Reset (async on arstn_i low, released synchronously), all outputs:
  - spi_cs_o = 1, spi_clk_o = CPOL, spi_mosi_o = 0
  - s_axis.tready = 0, m_axis.tvalid = 0, m_axis.tdata = 0
  - FSM = IDLE, all counters 0
- Reset mid-transaction: CS rises immediately, SCLK returns to CPOL, the word in flight is discarded and no m_axis output is produced.
- FSM states: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE:
  - s_axis.tready = 1 only while m_axis.tvalid = 0, i.e. at most one unconsumed RX word.
  - On handshake: latch tdata into tx_shift; go to SETUP.
  - spi_cs_o falls on the next clk.
  - spi_mosi_o = tx_shift MSB from the same clk, for both CPHA values.
- SETUP: lasts CLK_DIV cycles with SCLK at CPOL, then go to XFER.
- XFER:
  - Half-period timer counts 0..CLK_DIV-1. On wrap, SCLK toggles and edge_cnt increments.
  - 2*DATA_WIDTH edges total. Odd edges are leading, even edges are trailing.
  - CPHA=0: sample MISO into rx_shift on the leading edge; shift the next MOSI bit out on the trailing edge. Skip the shift on the final trailing edge.
  - CPHA=1: shift MOSI on the leading edge (this includes presenting the MSB at the first edge); sample MISO on the trailing edge.
  - Samples are captured in the same clk as the edge. MOSI updates in the same clk as the edge.
  - After edge 2*DATA_WIDTH, SCLK = CPOL again; go to HOLD.
- HOLD: lasts CLK_DIV cycles with CS still low. On exit:
  - spi_cs_o = 1
  - m_axis.tdata = rx_shift, m_axis.tvalid = 1 in the same clk
  - go to GAP
- GAP: lasts CLK_DIV cycles with CS high and tready = 0. This guarantees the slave sees its CS-high reset. Then go to IDLE.
- Timing:
  - CS-low window = CLK_DIV*(2*DATA_WIDTH+2) cycles.
  - Minimum word-to-word period = CLK_DIV*(2*DATA_WIDTH+3)+1 cycles.
- m_axis:
  - tvalid holds, with tdata stable, until tready is high.
  - tvalid clears in the clk after the handshake.
  - No new s_axis word is accepted while tvalid = 1.
- Counters:
  - edge_cnt width = $clog2(2*DATA_WIDTH+1).
  - Timer width = $clog2(CLK_DIV+1).
  - No wrap-around occurs within a transaction.
- s_axis.tvalid dropping after the handshake has no effect. tdata is sampled only on the handshake clk.

Test Plan:
- Mode 0, CLK_DIV=4, MOSI looped to MISO, send 0xA5 -> spi_cs_o low for exactly 72 clk, 8 rising SCLK edges, m_axis.tdata = 0xA5 with tvalid rising in the clk CS rises.
- Mode 1 against an axis_spi_slave instance preloaded with 0x3C; master sends 0xC3 -> master m_axis = 0x3C and slave m_axis = 0xC3.
- Modes 2 and 3, MISO driven by a bench model shifting 0x81 -> SCLK idle high, 0x81 received, MOSI bits change only on the correct edges per CPHA.
- Backpressure: m_axis.tready = 0 after the first word, s_axis.tvalid held high with 0x11 then 0x22 -> second CS frame never starts, s_axis.tready stays 0. Release tready -> 0x22 starts ≥ CLK_DIV cycles after CS high, and 0x11 is delivered first.
- Reset mid-XFER after edge 5 -> same or next clk: CS = 1, SCLK = CPOL, m_axis.tvalid = 0. A following word 0x5A completes normally.
- CLK_DIV=1, DATA_WIDTH=16, back-to-back words 0xBEEF and 0x1234 -> SCLK = clk/2, CS-low window = 34 clk, GAP ≥ 1 clk, both words echoed in order.

Source files
------------

// File: rtl/axis_if.sv
// AXI-Stream handshake bundle (tdata/tvalid/tready) shared by the SPI link blocks.
// The master modport drives data, the slave modport drives tready.
interface axis_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_spi_master.sv
// AXI-Stream to SPI master: each s_axis word becomes one CS-framed SPI transfer and the
// word shifted in on MISO is returned on m_axis. SCLK is a divided, registered signal.
module axis_spi_master #(
   parameter int unsigned SPI_MODE   = 1,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic   clk_i,
   input  logic   arstn_i,
   output logic   spi_clk_o,
   output logic   spi_cs_o,
   output logic   spi_mosi_o,
   input  logic   spi_miso_i,
   axis_if.slave  s_axis,
   axis_if.master m_axis
);

   localparam bit          CPOL     = SPI_MODE[1];
   localparam bit          CPHA     = SPI_MODE[0];
   localparam int unsigned NumEdges = 2 * DATA_WIDTH;
   localparam int unsigned TimerW   = $clog2(CLK_DIV + 1);
   localparam int unsigned EdgeW    = $clog2(NumEdges + 1);

   localparam logic [TimerW-1:0] TimerLast = TimerW'(CLK_DIV - 1);
   localparam logic [EdgeW-1:0]  EdgeLast  = EdgeW'(NumEdges - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StSetup = 3'd1;
   localparam logic [2:0] StXfer  = 3'd2;
   localparam logic [2:0] StHold  = 3'd3;
   localparam logic [2:0] StGap   = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [TimerW-1:0]     timer_q, timer_d;
   logic [EdgeW-1:0]      edge_cnt_q, edge_cnt_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  tready_q, tready_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_q, cs_d;
   logic                  mosi_q, mosi_d;

   logic             timer_wrap;
   logic             last_edge;
   logic             leading;
   logic [EdgeW-1:0] edge_next;

   assign timer_wrap = (timer_q == TimerLast);
   assign last_edge  = (edge_cnt_q == EdgeLast);
   assign edge_next  = edge_cnt_q + EdgeW'(1);
   // Edges are numbered from 1, so odd numbers are leading edges.
   assign leading    = edge_next[0];

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      edge_cnt_d = edge_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      sclk_d     = sclk_q;
      cs_d       = cs_q;
      mosi_d     = mosi_q;

      if (rx_valid_q && m_axis.tready) begin
         rx_valid_d = 1'b0;
      end

      if (state_q != StIdle) begin
         timer_d = timer_wrap ? '0 : timer_q + TimerW'(1);
      end

      case (state_q)
         StIdle: begin
            if (s_axis.tvalid && tready_q) begin
               tx_shift_d = s_axis.tdata;
               mosi_d     = s_axis.tdata[DATA_WIDTH-1];
               cs_d       = 1'b0;
               timer_d    = '0;
               state_d    = StSetup;
            end
         end

         StSetup: begin
            if (timer_wrap) begin
               state_d = StXfer;
            end
         end

         StXfer: begin
            if (timer_wrap) begin
               sclk_d     = ~sclk_q;
               edge_cnt_d = edge_next;
               if (leading != CPHA) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], spi_miso_i};
               end else if (CPHA && (edge_cnt_q == '0)) begin
                  mosi_d = tx_shift_q[DATA_WIDTH-1];
               end else if (CPHA || !last_edge) begin
                  // CPHA=0 has no bit left to present after the final trailing edge.
                  tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                  mosi_d     = tx_shift_q[DATA_WIDTH-2];
               end
               if (last_edge) begin
                  edge_cnt_d = '0;
                  state_d    = StHold;
               end
            end
         end

         StHold: begin
            if (timer_wrap) begin
               cs_d       = 1'b1;
               mosi_d     = 1'b0;
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               state_d    = StGap;
            end
         end

         StGap: begin
            if (timer_wrap) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Registered so that tready is low while in reset and drops on the accepting clk.
      tready_d = (state_d == StIdle) && !rx_valid_d;
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         edge_cnt_q <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tready_q   <= 1'b0;
         sclk_q     <= CPOL;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         edge_cnt_q <= edge_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tready_q   <= tready_d;
         sclk_q     <= sclk_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
      end
   end

   assign spi_clk_o     = sclk_q;
   assign spi_cs_o      = cs_q;
   assign spi_mosi_o    = mosi_q;
   assign s_axis.tready = tready_q;
   assign m_axis.tvalid = rx_valid_q;
   assign m_axis.tdata  = rx_data_q;

endmodule

// File: tb/tb_axis_spi_master.sv
// Directed bench for axis_spi_master: loopback in mode 0, slave models in modes 1-3,
// backpressure, mid-transfer reset, and a CLK_DIV=1 / 16-bit back-to-back instance.
module tb_axis_spi_master;

   localparam int unsigned Cd0 = 4;
   localparam int unsigned CdG = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0_n;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- u0: mode 0, CLK_DIV=4, MOSI looped to MISO ----------------
   axis_if #(.DATA_WIDTH(8)) s0_if ();
   axis_if #(.DATA_WIDTH(8)) m0_if ();
   logic sclk0, cs0, mosi0;

   axis_spi_master #(.SPI_MODE(0), .DATA_WIDTH(8), .CLK_DIV(Cd0)) u0 (
      .clk_i      (clk),
      .arstn_i    (rst0_n),
      .spi_clk_o  (sclk0),
      .spi_cs_o   (cs0),
      .spi_mosi_o (mosi0),
      .spi_miso_i (mosi0),
      .s_axis     (s0_if),
      .m_axis     (m0_if)
   );

   int         nrise0 = 0, nfall0 = 0, lcnt0 = 0, rcnt0 = 0, win0 = 0, rises0 = 0;
   int         gap0 = 0, rise_cyc0 = 0;
   logic       tvr0 = 1'b0, p_cs0 = 1'b1, p_sclk0 = 1'b0;
   logic [7:0] q0[$];

   always @(negedge clk) begin
      if (m0_if.tvalid && m0_if.tready) q0.push_back(m0_if.tdata);
      if (!cs0) begin
         if (p_cs0) begin
            nfall0 <= nfall0 + 1;
            gap0   <= cyc - rise_cyc0;
            lcnt0  <= 1;
            rcnt0  <= 0;
         end else begin
            lcnt0 <= lcnt0 + 1;
            rcnt0 <= rcnt0 + int'(sclk0 && !p_sclk0);
         end
      end else if (!p_cs0) begin
         nrise0    <= nrise0 + 1;
         win0      <= lcnt0;
         rises0    <= rcnt0;
         tvr0      <= m0_if.tvalid;
         rise_cyc0 <= cyc;
      end
      p_cs0   <= cs0;
      p_sclk0 <= sclk0;
   end

   // ---------------- u4: mode 0, CLK_DIV=1, 16-bit, loopback ----------------
   axis_if #(.DATA_WIDTH(16)) s4_if ();
   axis_if #(.DATA_WIDTH(16)) m4_if ();
   logic sclk4, cs4, mosi4;

   axis_spi_master #(.SPI_MODE(0), .DATA_WIDTH(16), .CLK_DIV(1)) u4 (
      .clk_i      (clk),
      .arstn_i    (rst_n),
      .spi_clk_o  (sclk4),
      .spi_cs_o   (cs4),
      .spi_mosi_o (mosi4),
      .spi_miso_i (mosi4),
      .s_axis     (s4_if),
      .m_axis     (m4_if)
   );

   int          nrise4 = 0, lcnt4 = 0, tcnt4 = 0, since4 = 0, bad4 = 0, rise_cyc4 = 0;
   int          win4[$], tog4[$], gap4[$];
   logic        p_cs4 = 1'b1, p_sclk4 = 1'b0;
   logic [15:0] q4[$];

   always @(negedge clk) begin
      if (m4_if.tvalid && m4_if.tready) q4.push_back(m4_if.tdata);
      if (!cs4) begin
         if (p_cs4) begin
            if (nrise4 > 0) gap4.push_back(cyc - rise_cyc4);
            lcnt4  <= 1;
            tcnt4  <= 0;
            since4 <= 0;
         end else begin
            lcnt4 <= lcnt4 + 1;
            if (sclk4 != p_sclk4) begin
               tcnt4 <= tcnt4 + 1;
               // Toggles must be one clk apart once SCLK is running.
               if (tcnt4 > 0 && since4 > 0) bad4 <= bad4 + 1;
               since4 <= 0;
            end else begin
               since4 <= since4 + 1;
            end
         end
      end else if (!p_cs4) begin
         win4.push_back(lcnt4);
         tog4.push_back(tcnt4);
         rise_cyc4 <= cyc;
         nrise4    <= nrise4 + 1;
      end
      p_cs4   <= cs4;
      p_sclk4 <= sclk4;
   end

   // ---------------- g_m[1..3]: modes 1-3 against a bench SPI slave model ----------------
   logic [7:0] gs_tdata[1:3];
   logic       gs_tvalid;

   for (genvar g = 1; g <= 3; g++) begin : g_m
      localparam logic [1:0] Mode = 2'(g);
      localparam bit         Cpol = Mode[1];
      localparam bit         Cpha = Mode[0];
      localparam logic [7:0] Pre  = (g == 1) ? 8'h3C : 8'h81;

      axis_if #(.DATA_WIDTH(8)) s_if ();
      axis_if #(.DATA_WIDTH(8)) m_if ();
      logic sclk, cs, mosi;
      logic miso = 1'b0;

      assign s_if.tdata  = gs_tdata[g];
      assign s_if.tvalid = gs_tvalid;
      assign m_if.tready = 1'b1;

      axis_spi_master #(.SPI_MODE(g), .DATA_WIDTH(8), .CLK_DIV(CdG)) u_dut (
         .clk_i      (clk),
         .arstn_i    (rst_n),
         .spi_clk_o  (sclk),
         .spi_cs_o   (cs),
         .spi_mosi_o (mosi),
         .spi_miso_i (miso),
         .s_axis     (s_if),
         .m_axis     (m_if)
      );

      logic [7:0] sl_sh = 8'h00, sl_rx = 8'h00, got = 8'h00;
      logic       cs_m = 1'b1, p_m = 1'b0, p_s = 1'b0, p_c = 1'b1;
      int         n_got = 0, bad = 0;

      always @(cs or sclk) begin
         if (!cs) begin
            if (cs_m) begin
               sl_sh <= Pre;
               sl_rx <= 8'h00;
               miso  <= Cpha ? 1'b0 : Pre[7];
            end else if ((sclk != Cpol) != Cpha) begin
               sl_rx <= {sl_rx[6:0], mosi};
            end else if (Cpha) begin
               miso  <= sl_sh[7];
               sl_sh <= {sl_sh[6:0], 1'b0};
            end else begin
               miso  <= sl_sh[6];
               sl_sh <= {sl_sh[6:0], 1'b0};
            end
         end
         cs_m <= cs;
      end

      always @(negedge clk) begin
         if (m_if.tvalid) begin
            got   <= m_if.tdata;
            n_got <= n_got + 1;
         end
         // MOSI may change inside the frame only on the shifting SCLK edge.
         if (!cs && !p_c && (mosi != p_m)) begin
            if (sclk == p_s) bad <= bad + 1;
            else if ((sclk != Cpol) != Cpha) bad <= bad + 1;
         end
         p_m <= mosi;
         p_s <= sclk;
         p_c <= cs;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send0(input logic [7:0] d, output bit ok);
      s0_if.tdata  = d;
      s0_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (s0_if.tready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      s0_if.tvalid = 1'b0;
   endtask

   task automatic wait_rise0(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (nrise0 >= target) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit seen;
      int nf;
      int nq;
      int t;
      logic p;

      rst0_n       = 1'b0;
      rst_n        = 1'b0;
      s0_if.tdata  = 8'h00;
      s0_if.tvalid = 1'b0;
      m0_if.tready = 1'b1;
      s4_if.tdata  = 16'h0000;
      s4_if.tvalid = 1'b0;
      m4_if.tready = 1'b1;
      gs_tvalid    = 1'b0;
      gs_tdata[1]  = 8'hC3;
      gs_tdata[2]  = 8'h5A;
      gs_tdata[3]  = 8'h96;

      #12;
      check_eq("rst_cs", cs0, 1'b1);
      check_eq("rst_sclk", sclk0, 1'b0);
      check_eq("rst_mosi", mosi0, 1'b0);
      check_eq("rst_s_tready", s0_if.tready, 1'b0);
      check_eq("rst_m_tvalid", m0_if.tvalid, 1'b0);
      check_eq("rst_m_tdata", m0_if.tdata, 8'h00);
      check_eq("rst_sclk_mode2", g_m[2].sclk, 1'b1);
      check_eq("rst_sclk_mode3", g_m[3].sclk, 1'b1);

      @(posedge clk);
      #3;
      rst0_n = 1'b1;
      rst_n  = 1'b1;
      tick();

      // Modes 1-3: one word each, all three instances in lockstep.
      gs_tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (g_m[1].s_if.tready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      gs_tvalid = 1'b0;
      check_eq("modes_accept", ok, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (g_m[1].n_got > 0 && g_m[2].n_got > 0 && g_m[3].n_got > 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_eq("modes_done", ok, 1'b1);
      check_eq("m1_rx", g_m[1].got, 8'h3C);
      check_eq("m1_slave_rx", g_m[1].sl_rx, 8'hC3);
      check_eq("m2_rx", g_m[2].got, 8'h81);
      check_eq("m2_slave_rx", g_m[2].sl_rx, 8'h5A);
      check_eq("m3_rx", g_m[3].got, 8'h81);
      check_eq("m3_slave_rx", g_m[3].sl_rx, 8'h96);
      check_eq("m1_mosi_edges", g_m[1].bad, 0);
      check_eq("m2_mosi_edges", g_m[2].bad, 0);
      check_eq("m3_mosi_edges", g_m[3].bad, 0);
      check_eq("m2_sclk_idle", g_m[2].sclk, 1'b1);
      check_eq("m3_sclk_idle", g_m[3].sclk, 1'b1);

      // Mode 0 loopback, 0xA5.
      send0(8'hA5, ok);
      check_eq("a5_accept", ok, 1'b1);
      wait_rise0(1, ok);
      check_eq("a5_frame", ok, 1'b1);
      check_eq("a5_cs_window", win0, 72);
      check_eq("a5_sclk_rises", rises0, 8);
      check_eq("a5_tvalid_at_cs_rise", tvr0, 1'b1);
      tick();
      check_eq("a5_count", q0.size(), 1);
      check_eq("a5_data", q0[0], 8'hA5);

      // Backpressure: 0x11 stalls on m_axis, 0x22 must wait.
      m0_if.tready = 1'b0;
      send0(8'h11, ok);
      check_eq("bp_accept_11", ok, 1'b1);
      s0_if.tdata  = 8'h22;
      s0_if.tvalid = 1'b1;
      wait_rise0(2, ok);
      check_eq("bp_frame_11", ok, 1'b1);
      nf   = nfall0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (s0_if.tready) seen = 1'b1;
      end
      check_eq("bp_tready_low", seen, 1'b0);
      check_eq("bp_no_frame", nfall0, nf);
      check_eq("bp_tvalid_held", m0_if.tvalid, 1'b1);
      check_eq("bp_tdata_held", m0_if.tdata, 8'h11);
      m0_if.tready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (s0_if.tready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      s0_if.tvalid = 1'b0;
      check_eq("bp_accept_22", ok, 1'b1);
      wait_rise0(3, ok);
      check_eq("bp_frame_22", ok, 1'b1);
      check_eq("bp_gap_ge_div", 32'(gap0 >= int'(Cd0)), 1);
      tick();
      check_eq("bp_count", q0.size(), 3);
      check_eq("bp_first", q0[1], 8'h11);
      check_eq("bp_second", q0[2], 8'h22);

      // Reset right after SCLK edge 5 of a transfer.
      send0(8'h3E, ok);
      t = 0;
      p = sclk0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (sclk0 != p) t++;
         p = sclk0;
         if (t == 5) break;
      end
      check_eq("rst_mid_edges", t, 5);
      rst0_n = 1'b0;
      #1;
      check_eq("rst_mid_cs", cs0, 1'b1);
      check_eq("rst_mid_sclk", sclk0, 1'b0);
      check_eq("rst_mid_tvalid", m0_if.tvalid, 1'b0);
      #10;
      rst0_n = 1'b1;
      nq = q0.size();
      repeat (100) tick();
      check_eq("rst_mid_no_output", q0.size(), nq);
      check_eq("rst_mid_tvalid_after", m0_if.tvalid, 1'b0);
      nf = nrise0;
      send0(8'h5A, ok);
      check_eq("post_rst_accept", ok, 1'b1);
      wait_rise0(nf + 1, ok);
      check_eq("post_rst_frame", ok, 1'b1);
      check_eq("post_rst_window", win0, 72);
      tick();
      check_eq("post_rst_count", q0.size(), nq + 1);
      check_eq("post_rst_data", q0[nq], 8'h5A);

      // CLK_DIV=1, 16-bit, back-to-back.
      s4_if.tdata  = 16'hBEEF;
      s4_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (s4_if.tready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      s4_if.tdata = 16'h1234;
      check_eq("b2b_accept_1", ok, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (s4_if.tready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      s4_if.tvalid = 1'b0;
      check_eq("b2b_accept_2", ok, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (q4.size() >= 2) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_eq("b2b_done", ok, 1'b1);
      check_eq("b2b_window_1", win4[0], 34);
      check_eq("b2b_window_2", win4[1], 34);
      check_eq("b2b_toggles", tog4[0], 32);
      check_eq("b2b_sclk_spacing", bad4, 0);
      check_eq("b2b_gap", gap4[0], 2);
      check_eq("b2b_word_1", q4[0], 16'hBEEF);
      check_eq("b2b_word_2", q4[1], 16'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
